// File: rtl/muldiv_pkg.sv
// Shared types and sizing helper for the multicycle multiply/divide unit.
// The MULDIV_DIV_EN build macro is consumed by muldiv_unit, not here.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // Iteration counter width; holds WIDTH-1 for any WIDTH >= 2.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of the shift-add multiplier or restoring divider
// on the 2*WIDTH+1 bit accumulator.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic [WIDTH-1:0]  opnd,
  input  logic              is_div,
  output logic [2*WIDTH:0]  acc_nxt
);

  localparam int unsigned AW = 2 * WIDTH + 1;

  logic [WIDTH:0]   sum;
  logic [AW-1:0]    sh;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // Multiply: conditional add into the upper half, then shift right.
    sum    = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shift remainder:quotient left, trial subtract the divisor.
    sh     = {acc[AW-2:0], 1'b0};
    rem_sh = sh[AW-1:WIDTH];
    diff   = {1'b0, rem_sh} - {2'b00, opnd};
    if (is_div) begin
      acc_nxt = diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
    end else begin
      acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MULDIV_DIV_EN to include the divide path and DivZero flag.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned HW = WIDTH + 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned AW = W2 + 1;
  localparam int unsigned CW = cnt_w(WIDTH);

  md_state_e        state;
  md_op_e           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opnd_q;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nxt;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             signed_op;
  logic             is_div;
  logic             op_ok;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef MULDIV_DIV_EN
  logic neg_r;
  logic b_zero;

  assign op_ok  = 1'b1;
  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign b_zero = (b_q == '0);
`else
  assign op_ok  = (md_op_e'(Op) == MD_MULT) || (md_op_e'(Op) == MD_MULTU);
  assign is_div = 1'b0;
  assign DivZero = 1'b0;
`endif

  assign signed_op = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign mag_a     = (signed_op && a_q[WIDTH-1]) ? ~a_q + WIDTH'(1) : a_q;
  assign mag_b     = (signed_op && b_q[WIDTH-1]) ? ~b_q + WIDTH'(1) : b_q;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc     (acc),
    .opnd    (opnd_q),
    .is_div  (is_div),
    .acc_nxt (acc_nxt)
  );

  // Sign correction applied in FIX; divide-by-zero overrides the quotient/remainder.
  always_comb begin
    prod   = neg_q ? ~acc[W2-1:0] + W2'(1) : acc[W2-1:0];
    res_hi = prod[W2-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      res_lo = neg_q ? ~acc[WIDTH-1:0] + WIDTH'(1) : acc[WIDTH-1:0];
      res_hi = neg_r ? ~acc[W2-1:WIDTH] + WIDTH'(1) : acc[W2-1:WIDTH];
      if (b_zero) begin
        res_hi = a_q;
        res_lo = '1;
      end
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      op_q   <= MD_MULT;
      a_q    <= '0;
      b_q    <= '0;
      opnd_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
`ifdef MULDIV_DIV_EN
      neg_r   <= 1'b0;
      DivZero <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (HiWrite) Hi <= WriteData;
          if (LoWrite) Lo <= WriteData;
          if (Start && op_ok) begin
            op_q  <= md_op_e'(Op);
            a_q   <= A;
            b_q   <= B;
            Busy  <= 1'b1;
            state <= ST_PREP;
`ifdef MULDIV_DIV_EN
            DivZero <= 1'b0;
`endif
          end
        end
        ST_PREP: begin
          // Multiply keeps the multiplier in the low half; divide keeps the dividend.
          acc    <= {HW'(0), is_div ? mag_a : mag_b};
          opnd_q <= is_div ? mag_b : mag_a;
          neg_q  <= signed_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          cnt    <= CW'(WIDTH - 1);
          state  <= ST_RUN;
`ifdef MULDIV_DIV_EN
          neg_r  <= signed_op && a_q[WIDTH-1];
`endif
        end
        ST_RUN: begin
          acc <= acc_nxt;
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_FIX: begin
          Hi    <= res_hi;
          Lo    <= res_lo;
          Done  <= 1'b1;
          state <= ST_DONE;
`ifdef MULDIV_DIV_EN
          DivZero <= is_div && b_zero;
`endif
        end
        ST_DONE: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_wr = 1'b0;
  logic         lo_wr = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   n_total = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .Start     (start),
    .Op        (op),
    .A         (a),
    .B         (b),
    .HiWrite   (hi_wr),
    .LoWrite   (lo_wr),
    .WriteData (wdata),
    .Busy      (busy),
    .Done      (done),
    .DivZero   (div_zero),
    .Hi        (hi),
    .Lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference results from native wide arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    case (o)
      2'd0: begin
        p = 64'(sx * sy);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'd1: begin
        p = {32'd0, x} * {32'd0, y};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (y == '0) begin
          e.hi = x;
          e.lo = '1;
          e.dz = 1'b1;
        end else if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          e.hi = 32'(r);
          e.lo = 32'(q);
        end else begin
          e.hi = x % y;
          e.lo = x / y;
        end
      end
    endcase
    return e;
  endfunction

  // Scoreboard consumer: every Done pulse must match the oldest pending result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_hi", {32'd0, hi}, {32'd0, e.hi});
        check("sb_lo", {32'd0, lo}, {32'd0, e.lo});
        check("sb_dz", {63'd0, div_zero}, {63'd0, e.dz});
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag, input bit poke_run, input bit poke_done);
    logic         accepted;
    exp_t         e;
    int           edges;
    int           bc;
    logic [W-1:0] hi0;
    logic [W-1:0] lo0;
    accepted = 1'b1;
`ifndef MULDIV_DIV_EN
    if (o[1]) accepted = 1'b0;
`endif
    e = model(o, x, y);
    @(negedge clk);
    hi0 = hi;
    lo0 = lo;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (accepted) sb_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_rise"}, {63'd0, busy}, {63'd0, accepted});
    if (accepted) begin
      check({tag, "_dz_clr"}, {63'd0, div_zero}, 64'd0);
      edges = 0;
      bc = 1;
      do begin
        @(posedge clk);
        #1 edges++;
        if (poke_run && edges == 5) begin
          hi_wr = 1'b1;
          lo_wr = 1'b1;
          wdata = 32'hDEAD_BEEF;
        end
        if (poke_run && edges == 6) begin
          hi_wr = 1'b0;
          lo_wr = 1'b0;
          check({tag, "_hiwr_busy"}, {32'd0, hi}, {32'd0, hi0});
          check({tag, "_lowr_busy"}, {32'd0, lo}, {32'd0, lo0});
        end
        if (busy) bc++;
      end while (!done && edges < 100);
      check({tag, "_latency"}, 64'(edges), 64'(W + 2));
      if (poke_done) begin
        start = 1'b1;
        op = 2'd1;
        a = 32'd3;
        b = 32'd3;
        hi_wr = 1'b1;
        wdata = 32'h1111_2222;
      end
      @(posedge clk);
      #1 start = 1'b0;
      hi_wr = 1'b0;
      check({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
      check({tag, "_busy_cycles"}, 64'(bc), 64'(W + 3));
      if (poke_done) begin
        @(posedge clk);
        #1 check({tag, "_start_in_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_hi_hold"}, {32'd0, hi}, {32'd0, e.hi});
        check({tag, "_lo_hold"}, {32'd0, lo}, {32'd0, e.lo});
      end
    end else begin
      repeat (W + 4) @(posedge clk);
      #1 check({tag, "_rej_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_rej_hi"}, {32'd0, hi}, {32'd0, hi0});
      check({tag, "_rej_lo"}, {32'd0, lo}, {32'd0, lo0});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz", {63'd0, div_zero}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;

    // MTHI / MTLO in IDLE.
    @(negedge clk);
    hi_wr = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 hi_wr = 1'b0;
    check("mthi", {32'd0, hi}, 64'h0000_0000_A5A5_A5A5);
    @(negedge clk);
    lo_wr = 1'b1;
    wdata = 32'h5A5A_1234;
    @(posedge clk);
    #1 lo_wr = 1'b0;
    check("mtlo", {32'd0, lo}, 64'h0000_0000_5A5A_1234);

    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b1, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0, 1'b1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0, 1'b0);
    run_op(2'd3, 32'd7, 32'd2, "divu", 1'b0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, 1'b0);
    run_op(2'd3, 32'h0000_1234, 32'd0, "divu_zero", 1'b0, 1'b0);
    run_op(2'd0, 32'd5, 32'd6, "mult_after_dz", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op(2'(i % 2), $urandom, $urandom, "rand_mul", 1'b0, 1'b0);
    end
    run_op(2'd2, 32'h8000_0000, 32'd1, "div_minint", 1'b0, 1'b0);

    // Reset during the 10th RUN cycle aborts with no later Done.
    @(negedge clk);
    start = 1'b1;
    op = 2'd1;
    a = 32'd9;
    b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    repeat (W + 6) @(posedge clk);
    #1 check("abort_idle", {63'd0, busy}, 64'd0);

    run_op(2'd1, 32'h0001_0000, 32'h0001_0000, "multu_recover", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
